// File: rtl/spuart.sv
// spuart: service-processor UART with a Wishbone-style MMIO slave port.
//
// Ports
//   clk, reset_n        system clock (rising edge), async active-low reset
//   adr_i[0:23]         byte address, only adr_i[20:21] (word select) decoded
//   stb_i, cyc_i, we_i  bus strobe, cycle and write enable
//   sel_i[0:3]          big-endian byte lanes; writes need sel_i[3]
//   dat_i[0:31]         write data, byte payload in dat_i[24:31]
//   ack_o               one-cycle acknowledge per access
//   dat_o[0:31]         read data while ack_o is high, zero otherwise
//   uart_txd, uart_rxd  serial lines (idle high), rxd asynchronous
//
// Register map (word select): 0 DATA, 1 STATUS, 2 DIVISOR, 3 reserved.
// Build option: define SPUART_RX_FIFO_EN for an 8-entry RX FIFO; without it
// the RX buffer is a single byte register.
module spuart #(
  parameter logic [15:0] DIVISOR_RESET = 16'd28
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [0:23] adr_i,
  input  logic        stb_i,
  input  logic        cyc_i,
  input  logic [0:3]  sel_i,
  input  logic        we_i,
  input  logic [0:31] dat_i,
  output logic        ack_o,
  output logic [0:31] dat_o,
  output logic        uart_txd,
  input  logic        uart_rxd
);

`ifdef SPUART_RX_FIFO_EN
  localparam int unsigned DEPTH = 8;
`else
  localparam int unsigned DEPTH = 1;
`endif
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Bus decode
  logic        access, access_q, wr_en, rd_en;
  logic [1:0]  word;
  logic [7:0]  wbyte;
  logic [15:0] wdiv;
  logic        unused_ok;

  assign access    = cyc_i && stb_i;
  assign word      = adr_i[20:21];
  assign wbyte     = dat_i[24:31];
  assign wdiv      = dat_i[16:31];
  assign wr_en     = ack_o && we_i && sel_i[3];
  assign rd_en     = ack_o && !we_i;
  assign unused_ok = ^{adr_i[0:19], adr_i[22:23], sel_i[0:2], dat_i[0:15]};

  // Ack only on the first cycle of an access, so a strobe held across
  // several cycles still produces a single pulse and a single side effect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      access_q <= 1'b0;
      ack_o    <= 1'b0;
    end else begin
      access_q <= access;
      ack_o    <= access && !access_q;
    end
  end

  // Registers, holding register, sticky flags
  logic [15:0] divisor;
  logic        hold_full, overrun, framing;
  logic [7:0]  hold_data;
  logic        tx_load, tx_bit_end;
  tx_state_t   tx_state;
  logic        rx_valid, rx_ferr;
  logic [7:0]  rx_data;
  logic        push_ok, pop;
  logic [3:0]  count;

  assign tx_load = hold_full && (tx_state == TX_IDLE || (tx_state == TX_STOP && tx_bit_end));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      divisor   <= DIVISOR_RESET;
      hold_full <= 1'b0;
      hold_data <= '0;
      overrun   <= 1'b0;
      framing   <= 1'b0;
    end else begin
      if (wr_en && word == 2'd0 && !hold_full) begin
        hold_full <= 1'b1;
        hold_data <= wbyte;
      end else if (tx_load) begin
        hold_full <= 1'b0;
      end
      if (wr_en && word == 2'd2)
        divisor <= (wdiv < 16'd4) ? 16'd4 : wdiv;
      if (rx_valid && !push_ok)              overrun <= 1'b1;
      else if (wr_en && word == 2'd1 && dat_i[28]) overrun <= 1'b0;
      if (rx_ferr)                           framing <= 1'b1;
      else if (wr_en && word == 2'd1 && dat_i[27]) framing <= 1'b0;
    end
  end

  // RX buffer; a pop in the same cycle frees room for a push into a full buffer
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;

  assign pop     = rd_en && word == 2'd0 && count != 4'd0;
  assign push_ok = rx_valid && (count != 4'(DEPTH) || pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= rx_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push_ok && !pop)      count <= count + 4'd1;
      else if (!push_ok && pop) count <= count - 4'd1;
    end
  end

  // Read mux
  logic tx_ready, tx_idle;
  assign tx_ready = !hold_full;
  assign tx_idle  = !hold_full && tx_state == TX_IDLE;

  always_comb begin
    dat_o = '0;
    if (rd_en) begin
      case (word)
        2'd0: if (count != 4'd0) dat_o = {24'h0, mem[rd_ptr]};
        2'd1: dat_o = {20'h0, count, 3'b000, framing, overrun, tx_idle, tx_ready, count != 4'd0};
        2'd2: dat_o = {16'h0, divisor};
        default: dat_o = '0;
      endcase
    end
  end

  // TX: bit length re-latched from DIVISOR at every bit boundary
  logic [15:0] tx_cnt, tx_div;
  logic [7:0]  tx_sh;
  logic [2:0]  tx_idx;

  assign tx_bit_end = (tx_cnt == tx_div - 16'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      uart_txd <= 1'b1;
      tx_cnt   <= '0;
      tx_div   <= DIVISOR_RESET;
      tx_sh    <= '0;
      tx_idx   <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: if (hold_full) begin
          tx_state <= TX_START;
          uart_txd <= 1'b0;
          tx_sh    <= hold_data;
          tx_cnt   <= '0;
          tx_div   <= divisor;
        end
        default: if (!tx_bit_end) begin
          tx_cnt <= tx_cnt + 16'd1;
        end else begin
          tx_cnt <= '0;
          tx_div <= divisor;
          case (tx_state)
            TX_START: begin
              tx_state <= TX_DATA;
              uart_txd <= tx_sh[0];
              tx_idx   <= '0;
            end
            TX_DATA: if (tx_idx == 3'd7) begin
              tx_state <= TX_STOP;
              uart_txd <= 1'b1;
            end else begin
              tx_idx   <= tx_idx + 3'd1;
              tx_sh    <= {1'b0, tx_sh[7:1]};
              uart_txd <= tx_sh[1];
            end
            default: if (hold_full) begin
              tx_state <= TX_START;
              uart_txd <= 1'b0;
              tx_sh    <= hold_data;
            end else begin
              tx_state <= TX_IDLE;
              uart_txd <= 1'b1;
            end
          endcase
        end
      endcase
    end
  end

  // RX synchronizer and edge detect
  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rxd;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // RX FSM; rx_brk holds STOP after a framing error until the line is high
  rx_state_t   rx_state;
  logic [15:0] rx_cnt, rx_div;
  logic [7:0]  rx_sh;
  logic [2:0]  rx_idx;
  logic        rx_brk, rx_sample;

  assign rx_sample = (rx_state == RX_START) ? (rx_cnt == {1'b0, rx_div[15:1]} - 16'd1)
                                            : (rx_cnt == rx_div - 16'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_div   <= DIVISOR_RESET;
      rx_sh    <= '0;
      rx_idx   <= '0;
      rx_brk   <= 1'b0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (rx_state)
        RX_IDLE: if (rx_prev && !rx_sync) begin
          rx_state <= RX_START;
          rx_cnt   <= '0;
          rx_div   <= divisor;
        end
        RX_START: if (!rx_sample) begin
          rx_cnt <= rx_cnt + 16'd1;
        end else if (rx_sync) begin
          rx_state <= RX_IDLE;
        end else begin
          rx_state <= RX_DATA;
          rx_cnt   <= '0;
          rx_idx   <= '0;
          rx_div   <= divisor;
        end
        RX_DATA: if (!rx_sample) begin
          rx_cnt <= rx_cnt + 16'd1;
        end else begin
          rx_sh  <= {rx_sync, rx_sh[7:1]};
          rx_cnt <= '0;
          rx_div <= divisor;
          if (rx_idx == 3'd7) rx_state <= RX_STOP;
          else                rx_idx   <= rx_idx + 3'd1;
        end
        default: if (rx_brk) begin
          if (rx_sync) begin
            rx_brk   <= 1'b0;
            rx_state <= RX_IDLE;
          end
        end else if (!rx_sample) begin
          rx_cnt <= rx_cnt + 16'd1;
        end else if (rx_sync) begin
          rx_valid <= 1'b1;
          rx_data  <= rx_sh;
          rx_state <= RX_IDLE;
        end else begin
          rx_ferr <= 1'b1;
          rx_brk  <= 1'b1;
        end
      endcase
    end
  end

endmodule
